// File: rtl/cu_pkg.sv
// Shared types and encodings for the control unit sequencer and its decoder.
// CU_SINGLE_STEP_EN adds the STEP_WAIT state used after each retired instruction.
package cu_pkg;

  typedef enum logic [2:0] {
    INIT,
    FETCH_L,
    FETCH_H,
    EXEC,
    EXEC2,
    HALT
`ifdef CU_SINGLE_STEP_EN
    , STEP_WAIT
`endif
  } state_t;

`ifdef CU_SINGLE_STEP_EN
  localparam state_t RETIRE_STATE = STEP_WAIT;
`else
  localparam state_t RETIRE_STATE = FETCH_L;
`endif

  localparam logic [5:0] OP_BRA  = 6'h00;
  localparam logic [5:0] OP_BNE  = 6'h01;
  localparam logic [5:0] OP_LDI  = 6'h02;
  localparam logic [5:0] OP_ADD  = 6'h03;
  localparam logic [5:0] OP_SUB  = 6'h04;
  localparam logic [5:0] OP_LDAR = 6'h05;
  localparam logic [5:0] OP_LD   = 6'h06;
  localparam logic [5:0] OP_ST   = 6'h07;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam logic [4:0] ALU_ADD    = 5'b10100;
  localparam logic [4:0] ALU_SUB    = 5'b10110;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b10;
  localparam logic [1:0] MUX_IMM = 2'b11;

  localparam logic [1:0] OUTD_AR = 2'b00;
  localparam logic [1:0] OUTD_SP = 2'b01;
  localparam logic [1:0] OUTD_PC = 2'b10;

  // Active-low ARF enables, bit order {PC, AR, SP}
  localparam logic [2:0] ARF_EN_ALL  = 3'b000;
  localparam logic [2:0] ARF_EN_PC   = 3'b011;
  localparam logic [2:0] ARF_EN_AR   = 3'b101;
  localparam logic [2:0] ARF_EN_NONE = 3'b111;

  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [2:0] rf_fun_sel;
    logic [2:0] arf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_write;
    logic       ir_lh;
    logic       mem_cs;
    logic       mem_wr;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_IDLE = '{
    rf_outa_sel:  3'b000,
    rf_outb_sel:  3'b000,
    rf_fun_sel:   3'b000,
    arf_fun_sel:  3'b000,
    rf_reg_sel:   4'b1111,
    rf_scr_sel:   4'b1111,
    alu_fun_sel:  5'b00000,
    alu_wf:       1'b0,
    arf_outc_sel: 2'b00,
    arf_outd_sel: 2'b00,
    arf_reg_sel:  ARF_EN_NONE,
    ir_write:     1'b0,
    ir_lh:        1'b0,
    mem_cs:       1'b1,
    mem_wr:       1'b0,
    mux_a_sel:    2'b00,
    mux_b_sel:    2'b00,
    mux_c_sel:    1'b0,
    halted:       1'b0,
    illegal:      1'b0
  };

  // Active-low one-hot RF enable; R1 sits in bit 3
  function automatic logic [3:0] rf_enable(input logic [1:0] r);
    return ~(4'b1000 >> r);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control-bundle decoder: state, Run, IR contents and Z flag in,
// every datapath select/enable out.
module cu_decode
  import cu_pkg::*;
(
  input  logic [2:0]        state,
  input  logic              run,
  input  logic [15:0]       ir,
  input  logic              z_flag,
  output logic [CTRL_W-1:0] ctrl
);

  state_t     st;
  logic [5:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  ctrl_t      c;
  logic       unused_imm;

  assign st         = state_t'(state);
  assign opcode     = ir[15:10];
  assign rd         = ir[9:8];
  assign rs         = ir[7:6];
  assign unused_imm = ^ir[5:0];
  assign ctrl       = c;

  always_comb begin
    c = CTRL_IDLE;
    case (st)
      INIT: begin
        c.rf_fun_sel  = FUN_CLR;
        c.rf_reg_sel  = 4'b0000;
        c.rf_scr_sel  = 4'b0000;
        c.arf_fun_sel = FUN_CLR;
        c.arf_reg_sel = ARF_EN_ALL;
      end
      FETCH_L, FETCH_H: begin
        // Run gates only the low-byte fetch; the high byte always follows
        if (st == FETCH_H || run) begin
          c.arf_outd_sel = OUTD_PC;
          c.mem_cs       = 1'b0;
          c.ir_write     = 1'b1;
          c.ir_lh        = (st == FETCH_H);
          c.arf_fun_sel  = FUN_INC;
          c.arf_reg_sel  = ARF_EN_PC;
        end
      end
      EXEC: begin
        case (opcode)
          OP_BRA, OP_BNE: begin
            if (opcode == OP_BRA || !z_flag) begin
              c.mux_b_sel   = MUX_IMM;
              c.arf_fun_sel = FUN_LOAD;
              c.arf_reg_sel = ARF_EN_PC;
            end
          end
          OP_LDI: begin
            c.mux_a_sel  = MUX_IMM;
            c.rf_fun_sel = FUN_LOAD;
            c.rf_reg_sel = rf_enable(rd);
          end
          OP_ADD, OP_SUB: begin
            c.rf_outa_sel = {1'b0, rd};
            c.rf_outb_sel = {1'b0, rs};
            c.alu_fun_sel = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
            c.alu_wf      = 1'b1;
            c.mux_a_sel   = MUX_ALU;
            c.rf_fun_sel  = FUN_LOAD;
            c.rf_reg_sel  = rf_enable(rd);
          end
          OP_LDAR: begin
            c.mux_b_sel   = MUX_IMM;
            c.arf_fun_sel = FUN_LOAD;
            c.arf_reg_sel = ARF_EN_AR;
          end
          OP_LD: begin
            c.arf_outd_sel = OUTD_AR;
            c.mem_cs       = 1'b0;
          end
          OP_ST: begin
            c.rf_outa_sel  = {1'b0, rd};
            c.alu_fun_sel  = ALU_PASS_A;
            c.mux_c_sel    = 1'b0;
            c.arf_outd_sel = OUTD_AR;
            c.mem_cs       = 1'b0;
            c.mem_wr       = 1'b1;
          end
          OP_HLT: ;
          default: c.illegal = 1'b1;
        endcase
      end
      EXEC2: begin
        c.arf_outd_sel = OUTD_AR;
        c.mem_cs       = 1'b0;
        c.mux_a_sel    = MUX_MEM;
        c.rf_fun_sel   = FUN_LOAD;
        c.rf_reg_sel   = rf_enable(rd);
      end
      HALT: c.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_sequencer.sv
// Multi-cycle control unit: INIT/FETCH_L/FETCH_H/EXEC/EXEC2/HALT sequencing with
// combinational control outputs. CU_SINGLE_STEP_EN adds a Step input and STEP_WAIT.
module control_unit_sequencer
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [2:0]  ARF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_Write,
  output logic        IR_LH,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic        Illegal
);

  state_t     state_reg;
  ctrl_t      ctrl;
  logic [5:0] opcode;
  logic       unused_flags;

  assign opcode       = IROut[15:10];
  assign unused_flags = ^ALUOutFlag[2:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= INIT;
    end else begin
      case (state_reg)
        INIT:    state_reg <= FETCH_L;
        FETCH_L: if (Run) state_reg <= FETCH_H;
        FETCH_H: state_reg <= EXEC;
        EXEC: begin
          if (opcode == OP_LD)       state_reg <= EXEC2;
          else if (opcode == OP_HLT) state_reg <= HALT;
          else                       state_reg <= RETIRE_STATE;
        end
        EXEC2:   state_reg <= RETIRE_STATE;
        HALT:    state_reg <= HALT;
`ifdef CU_SINGLE_STEP_EN
        STEP_WAIT: if (Step) state_reg <= FETCH_L;
`endif
        default: state_reg <= INIT;
      endcase
    end
  end

  cu_decode u_decode (
    .state  (state_reg),
    .run    (Run),
    .ir     (IROut),
    .z_flag (ALUOutFlag[3]),
    .ctrl   (ctrl)
  );

  assign RF_OutASel  = ctrl.rf_outa_sel;
  assign RF_OutBSel  = ctrl.rf_outb_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign RF_RegSel   = ctrl.rf_reg_sel;
  assign RF_ScrSel   = ctrl.rf_scr_sel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ALU_WF      = ctrl.alu_wf;
  assign ARF_OutCSel = ctrl.arf_outc_sel;
  assign ARF_OutDSel = ctrl.arf_outd_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_Write    = ctrl.ir_write;
  assign IR_LH       = ctrl.ir_lh;
  assign Mem_CS      = ctrl.mem_cs;
  // A write strobe is never presented without chip select
  assign Mem_WR      = ctrl.mem_wr & ~ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign Halted      = ctrl.halted;
  assign Illegal     = ctrl.illegal;

endmodule

// File: tb/tb_control_unit_sequencer.sv
// Table-driven check of the control bundle per instruction phase, plus hand
// sequences for Run deassertion, HLT, asynchronous reset and single-step.
module tb_control_unit_sequencer;

  typedef struct packed {
    logic [2:0] a_sel;
    logic [2:0] b_sel;
    logic [2:0] rf_fun;
    logic [2:0] arf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] c_sel;
    logic [1:0] d_sel;
    logic [2:0] arf_reg;
    logic       ir_w;
    logic       ir_lh;
    logic       cs;
    logic       wr;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
    logic       illegal;
  } obs_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        z;
    obs_t        exec;
    logic        two;
    obs_t        exec2;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic        Step;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, ARF_RegSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF, IR_Write, IR_LH, Mem_CS, Mem_WR, MuxCSel, Halted, Illegal;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;

  int passed = 0;
  int total  = 0;

  obs_t got;
  obs_t IDLE, INIT_B, FL, FH, HALT_B, e;
  vec_t vecs[12];

  always #5 Clock = ~Clock;

  control_unit_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Run         (Run),
`ifdef CU_SINGLE_STEP_EN
    .Step        (Step),
`endif
    .IROut       (IROut),
    .ALUOutFlag  (ALUOutFlag),
    .RF_OutASel  (RF_OutASel),
    .RF_OutBSel  (RF_OutBSel),
    .RF_FunSel   (RF_FunSel),
    .ARF_FunSel  (ARF_FunSel),
    .RF_RegSel   (RF_RegSel),
    .RF_ScrSel   (RF_ScrSel),
    .ALU_FunSel  (ALU_FunSel),
    .ALU_WF      (ALU_WF),
    .ARF_OutCSel (ARF_OutCSel),
    .ARF_OutDSel (ARF_OutDSel),
    .ARF_RegSel  (ARF_RegSel),
    .IR_Write    (IR_Write),
    .IR_LH       (IR_LH),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel),
    .Halted      (Halted),
    .Illegal     (Illegal)
  );

  assign got = {RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, RF_RegSel, RF_ScrSel,
                ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_RegSel, IR_Write,
                IR_LH, Mem_CS, Mem_WR, MuxASel, MuxBSel, MuxCSel, Halted, Illegal};

  task automatic check(input string name, input obs_t exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h required %h", name, got, exp);
    else begin
      passed++;
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Entered just after a negedge with the DUT in FETCH_L and Run=1
  task automatic run_vec(input vec_t v);
    IROut      = v.ir;
    ALUOutFlag = {v.z, 3'b000};
    #1 check($sformatf("%s/fetch_l", v.name), FL);
    @(negedge Clock); #1 check($sformatf("%s/fetch_h", v.name), FH);
    @(negedge Clock); #1 check($sformatf("%s/exec", v.name), v.exec);
    if (v.two) begin
      @(negedge Clock); #1 check($sformatf("%s/exec2", v.name), v.exec2);
    end
`ifdef CU_SINGLE_STEP_EN
    @(negedge Clock); #1 check($sformatf("%s/step_wait", v.name), IDLE);
`endif
    @(negedge Clock);
  endtask

  initial begin
    IDLE = '0;
    IDLE.rf_reg = 4'b1111; IDLE.rf_scr = 4'b1111; IDLE.arf_reg = 3'b111; IDLE.cs = 1'b1;
    INIT_B = IDLE;
    INIT_B.rf_fun = 3'b011; INIT_B.rf_reg = 4'b0000; INIT_B.rf_scr = 4'b0000;
    INIT_B.arf_fun = 3'b011; INIT_B.arf_reg = 3'b000;
    FL = IDLE;
    FL.d_sel = 2'b10; FL.cs = 1'b0; FL.ir_w = 1'b1; FL.arf_fun = 3'b001; FL.arf_reg = 3'b011;
    FH = FL; FH.ir_lh = 1'b1;
    HALT_B = IDLE; HALT_B.halted = 1'b1;

    e = IDLE; e.mux_a = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b0111;
    vecs[0] = '{"LDI_R1", 16'h0805, 1'b0, e, 1'b0, IDLE};
    e = IDLE; e.a_sel = 3'b000; e.b_sel = 3'b001; e.alu_fun = 5'b10100; e.alu_wf = 1'b1;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0111;
    vecs[1] = '{"ADD_R1_R2", 16'h0C40, 1'b0, e, 1'b0, IDLE};
    vecs[2] = '{"BNE_z1", 16'h0420, 1'b1, IDLE, 1'b0, IDLE};
    e = IDLE; e.a_sel = 3'b010; e.b_sel = 3'b001; e.alu_fun = 5'b10110; e.alu_wf = 1'b1;
    e.rf_fun = 3'b010; e.rf_reg = 4'b1101;
    vecs[3] = '{"SUB_R3_R2", 16'h1240, 1'b1, e, 1'b0, IDLE};
    e = IDLE; e.mux_b = 2'b11; e.arf_fun = 3'b010; e.arf_reg = 3'b011;
    vecs[4] = '{"BNE_z0", 16'h0420, 1'b0, e, 1'b0, IDLE};
    vecs[5] = '{"BRA_z1", 16'h0010, 1'b1, e, 1'b0, IDLE};
    e = IDLE; e.mux_b = 2'b11; e.arf_fun = 3'b010; e.arf_reg = 3'b101;
    vecs[6] = '{"LDAR", 16'h1440, 1'b0, e, 1'b0, IDLE};
    e = IDLE; e.a_sel = 3'b000; e.alu_fun = 5'b10000; e.d_sel = 2'b00; e.cs = 1'b0; e.wr = 1'b1;
    vecs[7] = '{"ST_R1", 16'h1C00, 1'b0, e, 1'b0, IDLE};
    e.a_sel = 3'b011;
    vecs[8] = '{"ST_R4", 16'h1F00, 1'b0, e, 1'b0, IDLE};
    e = IDLE; e.cs = 1'b0; e.d_sel = 2'b00;
    vecs[9] = '{"LD_R2", 16'h1900, 1'b0, e, 1'b1, IDLE};
    vecs[9].exec2 = e;
    vecs[9].exec2.mux_a = 2'b10; vecs[9].exec2.rf_fun = 3'b010; vecs[9].exec2.rf_reg = 4'b1011;
    e = IDLE; e.illegal = 1'b1;
    vecs[10] = '{"ILLEGAL", 16'h4000, 1'b0, e, 1'b0, IDLE};
    e = IDLE; e.mux_a = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b1110;
    vecs[11] = '{"LDI_R4", 16'h0BFF, 1'b0, e, 1'b0, IDLE};

    Reset = 1'b0; Run = 1'b0; Step = 1'b1; IROut = 16'h0000; ALUOutFlag = 4'h0;
    #2 check("reset_init", INIT_B);
    @(negedge Clock); Reset = 1'b1;
    #1 check("init_after_release", INIT_B);
    @(negedge Clock); #1 check("fetch_l_run0", IDLE);
    @(negedge Clock); #1 check("fetch_l_run0_hold", IDLE);
    Run = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Run dropped in FETCH_H: instruction completes, then fetch stalls
    IROut = 16'h0805; ALUOutFlag = 4'h0;
    #1 check("run_drop/fetch_l", FL);
    @(negedge Clock); Run = 1'b0; #1 check("run_drop/fetch_h", FH);
    @(negedge Clock); #1 check("run_drop/exec", vecs[0].exec);
`ifdef CU_SINGLE_STEP_EN
    @(negedge Clock); #1 check("run_drop/step_wait", IDLE);
`endif
    @(negedge Clock); #1 check("run_drop/stall", IDLE);
    @(negedge Clock); #1 check("run_drop/stall2", IDLE);
    Run = 1'b1;

    IROut = 16'hFC00;
    #1 check("hlt/fetch_l", FL);
    @(negedge Clock); #1 check("hlt/fetch_h", FH);
    @(negedge Clock); #1 check("hlt/exec", IDLE);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock); #1 check($sformatf("hlt/halt%0d", i), HALT_B);
    end

    Reset = 1'b0;
    #1 check("reset_from_halt", INIT_B);
    @(negedge Clock); Reset = 1'b1; #1 check("reset_from_halt/init", INIT_B);
    @(negedge Clock); #1 check("after_reset/fetch_l", FL);
    @(negedge Clock); #1 check("after_reset/fetch_h", FH);
    Reset = 1'b0;
    #1 check("reset_in_fetch_h", INIT_B);
    @(negedge Clock); Reset = 1'b1; #1 check("reset_in_fetch_h/init", INIT_B);
    @(negedge Clock); #1 check("reset_in_fetch_h/fetch_l", FL);

`ifdef CU_SINGLE_STEP_EN
    Step = 1'b0; IROut = 16'h0805;
    @(negedge Clock); #1 check("step/fetch_h", FH);
    @(negedge Clock); #1 check("step/exec", vecs[0].exec);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock); #1 check($sformatf("step/wait%0d", i), IDLE);
    end
    Step = 1'b1;
    @(negedge Clock); Step = 1'b0; #1 check("step/pulse_fetch_l", FL);
    @(negedge Clock); #1 check("step/pulse_fetch_h", FH);
    @(negedge Clock); #1 check("step/pulse_exec", vecs[0].exec);
    @(negedge Clock); #1 check("step/rewait0", IDLE);
    @(negedge Clock); #1 check("step/rewait1", IDLE);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_unit_sequencer.md
CONTROL_UNIT_SEQUENCER -- requirements
Module: control_unit_sequencer

Interface
REQ-001 The block SHALL expose these ports (name direction width meaning), clock and reset first:
REQ-002 Clock  input  1  sole clock, rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Run  input  1  level; 1 permits instruction fetch.
REQ-005 IROut  input  16  IR contents: [15:10] opcode, [9:8] Rd, [7:6] Rs, [7:0] imm/address.
REQ-006 ALUOutFlag  input  4  registered ALU flags {Z,C,N,O}, Z = bit 3.
REQ-007 RF_OutASel, RF_OutBSel  output  3 each  RF read selects, 000=R1 to 011=R4.
REQ-008 RF_FunSel, ARF_FunSel  output  3 each  000 dec, 001 inc, 010 load, 011 clear.
REQ-009 RF_RegSel, RF_ScrSel  output  4 each  active-low enables, bit3=R1 to bit0=R4.
REQ-010 ALU_FunSel  output  5  10000 pass A, 10100 add, 10110 sub; ALU_WF  output  1  flag write.
REQ-011 ARF_OutCSel, ARF_OutDSel  output  2 each  OutD: 00 AR, 01 SP, 10 PC.
REQ-012 ARF_RegSel  output  3  active-low {PC,AR,SP}, bit2=PC.
REQ-013 IR_Write, IR_LH  output  1 each  IR load; LH 0=low byte, 1=high byte.
REQ-014 Mem_CS (active-low), Mem_WR (1=write)  output  1 each.
REQ-015 MuxASel, MuxBSel  output  2 each  00 ALUOut, 10 MemOut, 11 IR[7:0]; MuxCSel  output  1  0=ALUOut[7:0].
REQ-016 Halted, Illegal  output  1 each  status.

Function
REQ-017 Outputs SHALL be combinational from state and IROut; the "idle bundle" is: all RegSel/ScrSel ones, Mem_CS=1, Mem_WR=0, IR_Write=0, ALU_WF=0, all other selects zero.
REQ-018 States SHALL be INIT, FETCH_L, FETCH_H, EXEC, EXEC2, HALT.
REQ-019 INIT SHALL clear all registers: RF_FunSel=011, RF_RegSel=RF_ScrSel=0000, ARF_FunSel=011, ARF_RegSel=000. Next state is FETCH_L.
REQ-020 FETCH_L with Run=0 SHALL output the idle bundle and hold; with Run=1 it SHALL drive OutDSel=10, Mem_CS=0, IR_Write=1, IR_LH=0, PC increment (ARF_FunSel=001, ARF_RegSel=011). Next state is FETCH_H.
REQ-021 FETCH_H SHALL behave as FETCH_L with IR_LH=1 and no Run check. Next state is EXEC.
REQ-022 EXEC SHALL decode the opcode as: 0x00 BRA PC<=imm (MuxBSel=11, ARF load 011); 0x01 BNE same as BRA only if Z=0, else idle; 0x02 LDI Rd<=zero-extended imm (MuxASel=11); 0x03 ADD / 0x04 SUB Rd<=Rd op Rs with ALU_WF=1, MuxASel=00; 0x05 LDAR AR<=imm (ARF_RegSel=101).
REQ-023 0x06 LD SHALL spend two cycles: EXEC drives OutDSel=00 and Mem_CS=0; EXEC2 repeats these and adds MuxASel=10 with an Rd load.
REQ-024 0x07 ST SHALL drive OutASel=Rd, ALU pass A, MuxCSel=0, OutDSel=00, Mem_CS=0, Mem_WR=1 for one cycle.
REQ-025 0x3F HLT SHALL enter HALT. Any other opcode SHALL output the idle bundle, pulse Illegal=1 for that cycle, and act as a NOP.
REQ-026 After EXEC (except LD/HLT) or EXEC2, the next state SHALL be FETCH_L. Latency SHALL be 3 cycles per instruction, 4 for LD.
REQ-027 Run SHALL be sampled only in FETCH_L; deasserting it mid-instruction completes that instruction.
REQ-028 HALT SHALL output the idle bundle with Halted=1 and persist until Reset.
REQ-029 Each register/memory write SHALL occur in exactly one cycle; Mem_WR=1 with Mem_CS=1 SHALL never occur.

Reset
REQ-030 Reset low SHALL force INIT asynchronously (INIT bundle on outputs, Halted=0, Illegal=0), abandoning any partial instruction.
REQ-031 The first edge after release SHALL execute INIT, then FETCH_L.

Configuration
REQ-032 With CU_SINGLE_STEP_EN defined, the block SHALL add input Step (1-bit) and a state STEP_WAIT entered after each retired instruction; STEP_WAIT outputs the idle bundle until Step=1 is sampled, then goes to FETCH_L.
REQ-033 Without CU_SINGLE_STEP_EN, no Step port or STEP_WAIT SHALL exist; HALT behaviour is identical in both builds.

Structure
REQ-034 Package cu_pkg SHALL hold the state enum, opcode constants, FunSel/ALU/Mux encodings, and the idle-bundle constant.
REQ-035 Sub-module cu_decode (combinational: state + IROut + Z -> control bundle) SHALL be instantiated once.

Verification
REQ-036 Reset, Run=1, mem[0]=0x05, mem[1]=0x08 (LDI R1,5) -> INIT, FETCH_L, FETCH_H, EXEC; R1=0x0005, PC=0x0002.
REQ-037 R1=5, R2=0xFFFB, ADD 0x0C40 -> R1=0, Z=1; BNE 0x0420 not taken; after SUB giving Z=0, BNE taken -> PC=0x0020.
REQ-038 R1=0x1234, LDAR 0x1440, ST 0x1C00 -> mem[0x40]=0x34; LD 0x1900 -> R2=0x0034 over 4 cycles.
REQ-039 HLT 0xFC00 -> Halted=1, no Mem_CS=0 for 20 cycles; opcode 0x4000 -> one Illegal pulse, no writes, next fetch at PC+2.
REQ-040 Reset asserted in FETCH_H -> INIT bundle immediately, PC=0 after release; with CU_SINGLE_STEP_EN, Step=0 holds STEP_WAIT, and a 1-cycle Step pulse runs exactly one more instruction.
